// File: rtl/catch_game_ctrl.sv
// Catch-The-Light game control: LED placement, hit detection, scoring and round sequencing.
// Optional build macro CATCH_MISS_PENALTY_EN: a wrong-button press in play costs one point.
module catch_game_ctrl #(
    parameter int         NUM_LEDS    = 8,
    parameter int         HOLD_CYCLES = 16,
    parameter int         SCORE_W     = 8,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NUM_LEDS-1:0] btn,
    input  logic                time_up,
    output logic                timer_rst,
    output logic [NUM_LEDS-1:0] led,
    output logic [SCORE_W-1:0]  score,
    output logic                playing,
    output logic                game_over
);
    localparam int                  IDX_W     = $clog2(NUM_LEDS);
    localparam int                  HOLD_W    = $clog2(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0]  SCORE_MAX = '1;

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, OVER} state_t;

    state_t              state, next_state;
    logic [7:0]          lfsr;
    logic [7:0]          lfsr_next;
    logic [NUM_LEDS-1:0] btn_q;
    logic [NUM_LEDS-1:0] btn_edge;
    logic [NUM_LEDS-1:0] lit_mask;
    logic [IDX_W-1:0]    pos;
    logic [IDX_W-1:0]    cand;
    logic [IDX_W-1:0]    reloc_pos;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                hit;
    logic                hold_done;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s == SCORE_MAX) ? s : s + SCORE_W'(1);
    endfunction

`ifdef CATCH_MISS_PENALTY_EN
    logic wrong;

    function automatic logic [SCORE_W-1:0] floor_dec(input logic [SCORE_W-1:0] s);
        return (s == '0) ? s : s - SCORE_W'(1);
    endfunction

    assign wrong = |(btn_edge & ~lit_mask);
`endif

    // x^8+x^6+x^5+x^4+1, shifting toward the MSB
    assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    // Bumping a repeat by one guarantees a relocation always moves the light
    assign cand      = lfsr[IDX_W-1:0];
    assign reloc_pos = (cand == pos) ? cand + IDX_W'(1) : cand;

    assign lit_mask  = NUM_LEDS'(1) << pos;
    assign btn_edge  = btn & ~btn_q;
    assign hit       = |(btn_edge & lit_mask);
    assign hold_done = (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LOAD;
            LOAD:    next_state = PLAY;
            PLAY:    if (time_up) next_state = OVER;
            OVER:    if (start) next_state = LOAD;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        timer_rst = (state == IDLE) || (state == LOAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr      <= LFSR_SEED;
            btn_q     <= '1;
            pos       <= '0;
            hold_cnt  <= '0;
            led       <= '0;
            score     <= '0;
            playing   <= 1'b0;
            game_over <= 1'b0;
        end else begin
            lfsr      <= lfsr_next;
            btn_q     <= btn;
            playing   <= (next_state == PLAY);
            game_over <= (next_state == OVER);
            case (state)
                LOAD: begin
                    pos      <= reloc_pos;
                    led      <= NUM_LEDS'(1) << reloc_pos;
                    hold_cnt <= '0;
                end
                PLAY: begin
                    // time_up outranks a same-cycle hit
                    if (time_up) begin
                        led <= '0;
                    end else if (hit) begin
                        score    <= sat_inc(score);
                        pos      <= reloc_pos;
                        led      <= NUM_LEDS'(1) << reloc_pos;
                        hold_cnt <= '0;
                    end else begin
`ifdef CATCH_MISS_PENALTY_EN
                        if (wrong) score <= floor_dec(score);
`endif
                        if (hold_done) begin
                            pos      <= reloc_pos;
                            led      <= NUM_LEDS'(1) << reloc_pos;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                end
                default: begin
                    led <= '0;
                    if (next_state == LOAD) score <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_catch_game_ctrl.sv
// Randomized bench for catch_game_ctrl with an in-bench reference model of the game rules.
module tb_catch_game_ctrl;
    localparam int NUM_LEDS    = 8;
    localparam int HOLD_CYCLES = 16;
    localparam int SCORE_W     = 2;
    localparam int SMAX        = (1 << SCORE_W) - 1;
    localparam int SEED        = 8'hA5;

    localparam int S_IDLE = 0;
    localparam int S_LOAD = 1;
    localparam int S_PLAY = 2;
    localparam int S_OVER = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [NUM_LEDS-1:0] btn;
    logic                time_up;
    logic                timer_rst;
    logic [NUM_LEDS-1:0] led;
    logic [SCORE_W-1:0]  score;
    logic                playing;
    logic                game_over;

    catch_game_ctrl #(
        .NUM_LEDS   (NUM_LEDS),
        .HOLD_CYCLES(HOLD_CYCLES),
        .SCORE_W    (SCORE_W),
        .LFSR_SEED  (8'hA5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .btn      (btn),
        .time_up  (time_up),
        .timer_rst(timer_rst),
        .led      (led),
        .score    (score),
        .playing  (playing),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: game phase, pseudo-random source, light index, hold age, score
    int m_state;
    int m_lfsr;
    int m_pos;
    int m_hold;
    int m_score;
    int m_btnq;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int lfsr_adv(input int l);
        int fb;
        fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
        return ((l << 1) | fb) & 255;
    endfunction

    function automatic int m_led();
        return (m_state == S_PLAY) ? (1 << m_pos) : 0;
    endfunction

    task automatic model_step();
        int ed;
        int p;
        int np;
        bit got_hit;
        if (rst) begin
            m_state = S_IDLE;
            m_lfsr  = SEED;
            m_pos   = 0;
            m_hold  = 0;
            m_score = 0;
            m_btnq  = 255;
            return;
        end
        ed      = int'(btn) & ~m_btnq & 255;
        p       = m_lfsr % NUM_LEDS;
        np      = (p == m_pos) ? (p + 1) % NUM_LEDS : p;
        got_hit = ((ed >> m_pos) & 1) != 0;
        case (m_state)
            S_IDLE, S_OVER: begin
                if (start) begin
                    m_state = S_LOAD;
                    m_score = 0;
                end
            end
            S_LOAD: begin
                m_state = S_PLAY;
                m_pos   = np;
                m_hold  = 0;
            end
            S_PLAY: begin
                if (time_up) begin
                    m_state = S_OVER;
                end else if (got_hit) begin
                    m_score = (m_score == SMAX) ? SMAX : m_score + 1;
                    m_pos   = np;
                    m_hold  = 0;
                end else begin
`ifdef CATCH_MISS_PENALTY_EN
                    if (((ed & ~(1 << m_pos)) != 0) && m_score > 0) m_score = m_score - 1;
`endif
                    if (m_hold == HOLD_CYCLES - 1) begin
                        m_pos  = np;
                        m_hold = 0;
                    end else begin
                        m_hold = m_hold + 1;
                    end
                end
            end
            default: ;
        endcase
        m_btnq = int'(btn);
        m_lfsr = lfsr_adv(m_lfsr);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("led", 32'(led), 32'(m_led()));
        chk("score", 32'(score), 32'(m_score));
        chk("playing", 32'(playing), 32'(m_state == S_PLAY));
        chk("game_over", 32'(game_over), 32'(m_state == S_OVER));
        chk("timer_rst", 32'(timer_rst), 32'(m_state == S_IDLE || m_state == S_LOAD));
    endtask

    task automatic new_round();
        time_up = 1'b1;
        tick();
        time_up = 1'b0;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        tick();
    endtask

    task automatic press_lit();
        btn = NUM_LEDS'(1 << m_pos);
        tick();
    endtask

    initial begin
        int prev;
        int sat_exp[5];
        int miss_exp[3];
        sat_exp = '{1, 2, 3, 3, 3};
`ifdef CATCH_MISS_PENALTY_EN
        miss_exp = '{1, 0, 0};
`else
        miss_exp = '{2, 2, 2};
`endif

        rst     = 1'b1;
        start   = 1'b0;
        time_up = 1'b0;
        btn     = 8'hFF;
        tick();
        tick();
        chk("rst_led", 32'(led), 0);
        chk("rst_score", 32'(score), 0);
        chk("rst_playing", 32'(playing), 0);
        chk("rst_game_over", 32'(game_over), 0);
        chk("rst_timer_rst", 32'(timer_rst), 1);

        rst = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("load_timer_rst", 32'(timer_rst), 1);
        chk("load_led", 32'(led), 0);
        tick();
        chk("play_timer_rst", 32'(timer_rst), 0);
        chk("play_onehot", 32'($onehot(led)), 1);
        repeat (5) tick();
        chk("held_btn_score", 32'(score), 0);
        btn = '0;
        tick();

        prev = m_led();
        press_lit();
        chk("hit_score", 32'(score), 1);
        chk("hit_moved", 32'(int'(led) != prev), 1);
        chk("hit_onehot", 32'($onehot(led)), 1);
        btn = '0;
        tick();

        new_round();
        for (int n = 1; n <= 3 * HOLD_CYCLES; n++) begin
            prev = int'(led);
            tick();
            chk("hold_change", 32'(int'(led) != prev), 32'((n % HOLD_CYCLES) == 0));
        end
        chk("hold_score", 32'(score), 0);

        new_round();
        for (int i = 0; i < 5; i++) begin
            press_lit();
            chk("sat_score", 32'(score), 32'(sat_exp[i]));
            btn = '0;
            tick();
        end

        btn     = NUM_LEDS'(1 << m_pos);
        time_up = 1'b1;
        tick();
        chk("tu_score", 32'(score), 3);
        chk("tu_led", 32'(led), 0);
        chk("tu_game_over", 32'(game_over), 1);
        chk("tu_timer_rst", 32'(timer_rst), 0);
        btn     = '0;
        time_up = 1'b0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_score", 32'(score), 0);
        chk("restart_game_over", 32'(game_over), 0);
        chk("restart_timer_rst", 32'(timer_rst), 1);
        tick();

        repeat (2) begin
            press_lit();
            btn = '0;
            tick();
        end
        chk("miss_pre_score", 32'(score), 2);
        for (int i = 0; i < 3; i++) begin
            prev = m_led();
            btn  = NUM_LEDS'(1 << ((m_pos + 1) % NUM_LEDS));
            tick();
            chk("miss_score", 32'(score), 32'(miss_exp[i]));
            chk("miss_led", 32'(led), 32'(prev));
            btn = '0;
            tick();
        end

        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 499) == 0);
            start   = ($urandom_range(0, 7) == 0);
            time_up = ($urandom_range(0, 59) == 0);
            case ($urandom_range(0, 3))
                0:       btn = NUM_LEDS'(1 << m_pos);
                1:       btn = NUM_LEDS'($urandom);
                default: btn = '0;
            endcase
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
